// File: rtl/prga_prog_pkg.sv
// Shared types and constants for the PRGA fabric programming controller.
package prga_prog_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StLoad,
        StShift,
        StDone
    } prog_state_e;

endpackage

// File: rtl/prga_prog_shifter.sv
// Holds one bitstream word and serialises it MSB-first, CHAIN_W bits per beat.
module prga_prog_shifter
    import prga_prog_pkg::*;
#(
    parameter int unsigned CHAIN_W = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               shift,
    input  logic [WORD_W-1:0]  data,
    output logic [CHAIN_W-1:0] dout,
    output logic               last_beat
);

    localparam int unsigned BEATS  = WORD_W / CHAIN_W;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            beat_q <= '0;
        end else begin
            sreg_q <= sreg_d;
            beat_q <= beat_d;
        end
    end

    always_comb begin
        sreg_d = sreg_q;
        beat_d = beat_q;
        if (load) begin
            sreg_d = data;
            beat_d = '0;
        end else if (shift) begin
            sreg_d = sreg_q << CHAIN_W;
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    assign dout      = sreg_q[WORD_W-1 -: CHAIN_W];
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/prga_prog_ctrl.sv
// Programming-session controller: resets the fabric, then streams bitstream words
// into the scan chain one word at a time.
module prga_prog_ctrl
    import prga_prog_pkg::*;
#(
    parameter int unsigned CHAIN_W    = 1,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [CNT_W-1:0]   cfg_words,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [WORD_W-1:0]  wr_data,
    output logic               prog_rst,
    output logic               prog_we,
    output logic [CHAIN_W-1:0] prog_din,
    output logic               prog_done,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);

    prog_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rcnt_q, rcnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             pdone_q, pdone_d;
    logic             sh_load, sh_shift, sh_last;
    logic [CHAIN_W-1:0] sh_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pdone_q <= pdone_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rcnt_d   = rcnt_q;
        done_d   = done_q;
        err_d    = err_q;
        pdone_d  = pdone_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        if (cfg_abort && state_q != StIdle) begin
            state_d = StIdle;
            err_d   = 1'b1;
            done_d  = 1'b0;
            pdone_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // start together with abort is dropped silently
                    if (cfg_start && !cfg_abort) begin
                        if (cfg_words != '0) begin
                            state_d = StReset;
                            cnt_d   = cfg_words;
                            rcnt_d  = '0;
                            done_d  = 1'b0;
                            err_d   = 1'b0;
                            pdone_d = 1'b0;
                        end else begin
                            err_d  = 1'b1;
                            done_d = 1'b0;
                        end
                    end
                end
                StReset: begin
                    if (rcnt_q == RC_W'(RST_CYCLES - 1)) state_d = StLoad;
                    else rcnt_d = rcnt_q + RC_W'(1);
                end
                StLoad: begin
                    if (wr_valid) begin
                        sh_load = 1'b1;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    sh_shift = 1'b1;
                    if (sh_last) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            pdone_d = 1'b1;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
            if (cfg_start && state_q != StIdle) err_d = 1'b1;
        end
    end

    prga_prog_shifter #(
        .CHAIN_W (CHAIN_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .shift     (sh_shift),
        .data      (wr_data),
        .dout      (sh_dout),
        .last_beat (sh_last)
    );

    // Abort kills fabric-facing strobes in the same cycle it is seen.
    assign busy      = (state_q != StIdle);
    assign wr_ready  = (state_q == StLoad) && !cfg_abort;
    assign prog_rst  = (state_q == StReset) && !cfg_abort;
    assign prog_we   = (state_q == StShift) && !cfg_abort;
    assign prog_din  = prog_we ? sh_dout : '0;
    assign prog_done = pdone_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prga_prog_ctrl.sv
// Self-checking bench for prga_prog_ctrl: CHAIN_W=1 instance (a) and CHAIN_W=4 instance (b).
module tb_prga_prog_ctrl;

    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             cfg_start, cfg_abort, wr_valid;
    logic [CNT_W-1:0] cfg_words;
    logic [31:0]      wr_data_a;
    logic             wr_ready_a, prog_rst_a, prog_we_a, prog_done_a, busy_a, done_a, err_a;
    logic [0:0]       prog_din_a;

    logic             start_b, abort_b, valid_b;
    logic [CNT_W-1:0] words_b;
    logic [31:0]      data_b;
    logic             wr_ready_b, prog_rst_b, prog_we_b, prog_done_b, busy_b, done_b, err_b;
    logic [3:0]       prog_din_b;

    prga_prog_ctrl #(.CHAIN_W(1), .CNT_W(CNT_W), .RST_CYCLES(4)) dut_a (
        .clk (clk), .rst_n (rst_n), .cfg_start (cfg_start), .cfg_abort (cfg_abort),
        .cfg_words (cfg_words), .wr_valid (wr_valid), .wr_ready (wr_ready_a),
        .wr_data (wr_data_a), .prog_rst (prog_rst_a), .prog_we (prog_we_a),
        .prog_din (prog_din_a), .prog_done (prog_done_a), .busy (busy_a),
        .done (done_a), .err (err_a)
    );

    prga_prog_ctrl #(.CHAIN_W(4), .CNT_W(CNT_W), .RST_CYCLES(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .cfg_start (start_b), .cfg_abort (abort_b),
        .cfg_words (words_b), .wr_valid (valid_b), .wr_ready (wr_ready_b),
        .wr_data (data_b), .prog_rst (prog_rst_b), .prog_we (prog_we_b),
        .prog_din (prog_din_b), .prog_done (prog_done_b), .busy (busy_b),
        .done (done_b), .err (err_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Word source for instance a: advances on each accepted word.
    logic [31:0] word_tab [4];
    int          wr_idx = 0;
    always @(posedge clk) begin
        if (!busy_a) wr_idx <= 0;
        else if (wr_valid && wr_ready_a) wr_idx <= wr_idx + 1;
    end
    assign wr_data_a = word_tab[wr_idx[1:0]];

    // Scoreboard for instance a: bits pushed on acceptance, popped on each prog_we.
    logic [0:0] exp_q[$];
    int   we_cnt = 0, rst_cnt = 0, burst_cnt = 0, last_gap = 0, cyc = 0, last_we_cyc = 0;
    int   din_bad = 0;
    logic we_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (prog_rst_a) rst_cnt++;
        if (!prog_we_a && prog_din_a != 1'b0) din_bad++;
        if (prog_we_a) begin
            we_cnt++;
            if (!we_prev) begin
                burst_cnt++;
                last_gap = cyc - last_we_cyc - 1;
            end
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL we_no_word: prog_we high with no accepted word at cycle %0d", cyc);
            end else begin
                chk("din", prog_din_a, exp_q.pop_front());
            end
        end
        we_prev = prog_we_a;
        if (wr_valid && wr_ready_a)
            for (int i = 31; i >= 0; i--) exp_q.push_back(wr_data_a[i]);
        if (!busy_a) exp_q.delete();
    end

    logic [3:0] cap_b [8];
    int         we_cnt_b = 0;
    always @(negedge clk) begin
        if (prog_we_b) begin
            if (we_cnt_b < 8) cap_b[we_cnt_b] = prog_din_b;
            we_cnt_b++;
        end
    end

    typedef struct {
        logic             start;
        logic             abort;
        logic             valid;
        logic [CNT_W-1:0] words;
        logic [4:0]       exp;   // {busy, err, done, prog_rst, wr_ready}
    } vec_t;

    vec_t vt [8];
    int   b_we, b_rst, b_burst;

    task automatic snap();
        b_we    = we_cnt;
        b_rst   = rst_cnt;
        b_burst = burst_cnt;
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] w);
        cfg_words = w;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_a && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, busy_a, 1'b0);
    endtask

    task automatic wait_we(input string name, input int target);
        int n = 0;
        while ((we_cnt - b_we) < target && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_reach"}, we_cnt - b_we, target);
    endtask

    initial begin
        logic [3:0] exp_nib [8];
        int         n;
        exp_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

        vt[0] = '{1'b0, 1'b0, 1'b1, 16'd5, 5'b00000};
        vt[1] = '{1'b1, 1'b1, 1'b0, 16'd5, 5'b00000};
        vt[2] = '{1'b0, 1'b1, 1'b0, 16'd5, 5'b00000};
        vt[3] = '{1'b1, 1'b0, 1'b0, 16'd0, 5'b01000};
        vt[4] = '{1'b0, 1'b0, 1'b1, 16'd0, 5'b01000};
        vt[5] = '{1'b1, 1'b1, 1'b0, 16'd0, 5'b01000};
        vt[6] = '{1'b1, 1'b0, 1'b0, 16'd3, 5'b10010};
        vt[7] = '{1'b0, 1'b1, 1'b0, 16'd3, 5'b01000};

        word_tab[0] = 32'h8000_0001;
        word_tab[1] = 32'hA5A5_A5A5;
        word_tab[2] = 32'h0;
        word_tab[3] = 32'h0;

        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_abort = 1'b0; wr_valid = 1'b0; cfg_words = '0;
        start_b = 1'b0; abort_b = 1'b0; valid_b = 1'b0; words_b = '0; data_b = '0;
        #3;
        chk("reset_a", {wr_ready_a, prog_rst_a, prog_we_a, prog_din_a, prog_done_a,
                        busy_a, done_a, err_a}, '0);
        chk("reset_b", {wr_ready_b, prog_rst_b, prog_we_b, prog_din_b, prog_done_b,
                        busy_b, done_b, err_b}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Control corner cases from IDLE, one clock each.
        snap();
        for (int i = 0; i < 8; i++) begin
            cfg_start = vt[i].start;
            cfg_abort = vt[i].abort;
            wr_valid  = vt[i].valid;
            cfg_words = vt[i].words;
            @(posedge clk); #1;
            cfg_start = 1'b0;
            cfg_abort = 1'b0;
            wr_valid  = 1'b0;
            chk($sformatf("vec%0d", i), {busy_a, err_a, done_a, prog_rst_a, wr_ready_a},
                vt[i].exp);
            if (i == 5) chk("zero_start_no_rst", rst_cnt - b_rst, 0);
        end

        // Two back-to-back words, one-bit chain.
        snap();
        wr_valid = 1'b1;
        pulse_start(16'd2);
        wait_idle("two_words");
        chk("two_words_rst_cycles", rst_cnt - b_rst, 4);
        chk("two_words_we_cycles", we_cnt - b_we, 64);
        chk("two_words_bursts", burst_cnt - b_burst, 2);
        chk("two_words_gap", last_gap, 1);
        chk("two_words_flags", {done_a, prog_done_a, err_a}, 3'b110);
        chk("two_words_sb_empty", exp_q.size(), 0);

        // Spurious start during SHIFT must not disturb the session.
        word_tab[0] = 32'h0F0F_3C3C;
        word_tab[1] = 32'hDEAD_BEEF;
        snap();
        pulse_start(16'd2);
        chk("start_clears_done", {done_a, prog_done_a, busy_a}, 3'b001);
        wait_we("spurious", 5);
        cfg_words = 16'd7;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("spurious_err", {err_a, busy_a}, 2'b11);
        wait_idle("spurious");
        chk("spurious_we_cycles", we_cnt - b_we, 64);
        chk("spurious_rst_cycles", rst_cnt - b_rst, 4);
        chk("spurious_flags", {done_a, err_a}, 2'b11);

        // Abort on the 10th SHIFT cycle of word 1.
        snap();
        pulse_start(16'd2);
        wait_we("abort", 9);
        cfg_abort = 1'b1;
        #1;
        chk("abort_we_same_cycle", prog_we_a, 1'b0);
        @(posedge clk); #1;
        cfg_abort = 1'b0;
        chk("abort_state", {busy_a, prog_we_a, err_a, done_a, prog_done_a}, 5'b00100);
        chk("abort_we_cycles", we_cnt - b_we, 9);

        // Asynchronous reset mid-SHIFT, then a clean single-word session.
        snap();
        pulse_start(16'd2);
        wait_we("rst_mid", 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {wr_ready_a, prog_rst_a, prog_we_a, prog_din_a, prog_done_a,
                                busy_a, done_a, err_a}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        word_tab[0] = 32'hC3A5_0F96;
        snap();
        pulse_start(16'd1);
        wait_idle("post_rst");
        chk("post_rst_we_cycles", we_cnt - b_we, 32);
        chk("post_rst_rst_cycles", rst_cnt - b_rst, 4);
        chk("post_rst_flags", {done_a, prog_done_a, err_a}, 3'b110);
        wr_valid = 1'b0;

        // Four-bit chain, single word.
        data_b  = 32'h1234_5678;
        valid_b = 1'b1;
        words_b = 16'd1;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b_timeout", busy_b, 1'b0);
        chk("b_we_cycles", we_cnt_b, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("b_nibble%0d", i), cap_b[i], exp_nib[i]);
        chk("b_flags", {prog_done_b, done_b, err_b}, 3'b110);

        chk("din_zero_outside_shift", din_bad, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
